// File: rtl/pxs_stream_gen.sv
// pxs_stream_gen: head of the 26-bit overlay pixel stream.
// Generates VGA raster timing from a pair of 10-bit counters and registers one
// stream word per px_clk carrying position, sync, active flag and background RGB.
// Word layout (MSB..LSB): {B,G,R}[25:23], XC[22:13], YC[12:3], HS[2], VS[1], Active[0].
module pxs_stream_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic        px_clk,
  input  logic        reset,
  input  logic        en,
  input  logic [2:0]  bg_rgb,
  output logic [25:0] RGBStr_o,
  output logic        frame_start,
  output logic        line_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Both totals must fit the 10-bit position fields of the stream word.
  if (H_TOTAL > 1024 || H_TOTAL < 1) begin : g_h_total_check
    $fatal(1, "pxs_stream_gen: H_TOTAL=%0d must be in 1..1024", H_TOTAL);
  end
  if (V_TOTAL > 1024 || V_TOTAL < 1) begin : g_v_total_check
    $fatal(1, "pxs_stream_gen: V_TOTAL=%0d must be in 1..1024", V_TOTAL);
  end

  // Window bounds are held one bit wider than the counters so that bounds equal
  // to 1024 compare correctly.
  localparam logic [10:0] H_ACT_END   = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_BEG  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END  = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT_END   = 11'(V_ACTIVE);
  localparam logic [10:0] V_SYNC_BEG  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_END  = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0]  H_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST      = 10'(V_TOTAL - 1);

  typedef struct packed {
    logic [2:0] rgb;     // {B,G,R}
    logic [9:0] xc;
    logic [9:0] yc;
    logic       hs;
    logic       vs;
    logic       active;
  } px_word_t;

  // Idle word: blank, origin, both syncs at their inactive level.
  localparam px_word_t RESET_WORD = '{
    rgb:    3'b000,
    xc:     10'd0,
    yc:     10'd0,
    hs:     ~HS_POL,
    vs:     ~VS_POL,
    active: 1'b0
  };

  logic [9:0]  r_cx;
  logic [9:0]  r_cy;
  logic [9:0]  w_cx_next;
  logic [9:0]  w_cy_next;
  logic [10:0] w_cx_ext;
  logic [10:0] w_cy_ext;
  logic        w_active;
  px_word_t    w_word;
  px_word_t    r_word;
  logic        r_frame_start;
  logic        r_line_start;

  // Raster counter successor: cx wraps at end of line, cy advances on that wrap.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it
    // unassigned; an unassigned path would infer a latch.
    w_cx_next = r_cx + 10'd1;
    w_cy_next = r_cy;
    if (r_cx == H_LAST) begin
      w_cx_next = 10'd0;
      w_cy_next = (r_cy == V_LAST) ? 10'd0 : r_cy + 10'd1;
    end
  end

  // Raster counters advance only while en is high.
  always_ff @(posedge px_clk or posedge reset) begin
    if (reset) begin
      // NOTE: state registers use non-blocking assignments so every flop samples
      // the pre-edge values, independent of statement order.
      r_cx <= 10'd0;
      r_cy <= 10'd0;
    end else if (en) begin
      r_cx <= w_cx_next;
      r_cy <= w_cy_next;
    end
  end

  // Stream word for the current counter position; all fields describe the same pixel.
  always_comb begin
    w_cx_ext      = {1'b0, r_cx};
    w_cy_ext      = {1'b0, r_cy};
    w_active      = (w_cx_ext < H_ACT_END) && (w_cy_ext < V_ACT_END);
    w_word        = RESET_WORD;
    w_word.xc     = r_cx;
    w_word.yc     = r_cy;
    w_word.active = w_active;
    w_word.hs     = (w_cx_ext >= H_SYNC_BEG && w_cx_ext < H_SYNC_END) ? HS_POL : ~HS_POL;
    w_word.vs     = (w_cy_ext >= V_SYNC_BEG && w_cy_ext < V_SYNC_END) ? VS_POL : ~VS_POL;
    w_word.rgb    = w_active ? bg_rgb : 3'b000;
  end

  // Output register: loads one word per enabled edge, holds (including pulses) otherwise.
  always_ff @(posedge px_clk or posedge reset) begin
    if (reset) begin
      r_word        <= RESET_WORD;
      r_frame_start <= 1'b0;
      r_line_start  <= 1'b0;
    end else if (en) begin
      r_word        <= w_word;
      r_frame_start <= (r_cx == 10'd0) && (r_cy == 10'd0);
      r_line_start  <= (r_cx == 10'd0);
    end
  end

  assign RGBStr_o    = r_word;
  assign frame_start = r_frame_start;
  assign line_start  = r_line_start;

endmodule

// File: tb/tb_pxs_stream_gen.sv
// Directed bench for pxs_stream_gen: default VGA timing, a small raster for
// whole-frame checks, and a small raster with inverted sync polarity.
module tb_pxs_stream_gen;

  logic        px_clk;
  logic        rst_def, rst_sm, rst_pol;
  logic        en_def, en_sm, en_pol;
  logic [2:0]  bg;
  logic [25:0] word_def, word_sm, word_pol;
  logic        fs_def, fs_sm, fs_pol;
  logic        ls_def, ls_sm, ls_pol;

  int errors = 0;
  int checks = 0;

  pxs_stream_gen u_def (
    .px_clk(px_clk), .reset(rst_def), .en(en_def), .bg_rgb(bg),
    .RGBStr_o(word_def), .frame_start(fs_def), .line_start(ls_def)
  );

  pxs_stream_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(2),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) u_sm (
    .px_clk(px_clk), .reset(rst_sm), .en(en_sm), .bg_rgb(bg),
    .RGBStr_o(word_sm), .frame_start(fs_sm), .line_start(ls_sm)
  );

  pxs_stream_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(2),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) u_pol (
    .px_clk(px_clk), .reset(rst_pol), .en(en_pol), .bg_rgb(bg),
    .RGBStr_o(word_pol), .frame_start(fs_pol), .line_start(ls_pol)
  );

  initial px_clk = 1'b0;
  always #5 px_clk = ~px_clk;

  // Hard stop in case the directed sequence ever stalls.
  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [25:0] mk(input logic [2:0] rgb, input int xc, input int yc,
                                     input logic hs, input logic vs, input logic act);
    return {rgb, 10'(xc), 10'(yc), hs, vs, act};
  endfunction

  task automatic tick();
    @(posedge px_clk);
    #1;
  endtask

  initial begin
    int act_cnt, hs_low_cnt, hs_first, hs_last, blank_rgb_cnt, ls_cnt, ls_idx, fs_cnt, xc_err;
    int vs_low_cnt, vs_low_off, fs_idx, pol_hs_cnt, pol_hs_off, pol_vs_cnt;
    logic [25:0] last_sm;

    rst_def = 1'b1; rst_sm = 1'b1; rst_pol = 1'b1;
    en_def = 1'b0;  en_sm = 1'b0;  en_pol = 1'b0;
    bg = 3'b101;
    repeat (3) @(posedge px_clk);
    #1;

    // Reset state.
    check("rst_word_def", 32'(word_def), 32'(mk(3'b000, 0, 0, 1'b1, 1'b1, 1'b0)));
    check("rst_pulses_def", 32'({fs_def, ls_def}), 32'(0));
    check("rst_word_pol", 32'(word_pol), 32'(mk(3'b000, 0, 0, 1'b0, 1'b0, 1'b0)));

    // First words after release.
    rst_def = 1'b0; en_def = 1'b1;
    tick();
    check("first_word", 32'(word_def), 32'(mk(3'b101, 0, 0, 1'b1, 1'b1, 1'b1)));
    check("first_fs_ls", 32'({fs_def, ls_def}), 32'(2'b11));
    bg = 3'b011;
    tick();
    check("second_word_bg", 32'(word_def), 32'(mk(3'b011, 1, 0, 1'b1, 1'b1, 1'b1)));
    check("second_fs_ls", 32'({fs_def, ls_def}), 32'(2'b00));
    bg = 3'b101;

    // Horizontal timing over one full line period (XC 2..799 of line 0, then 0..1 of line 1).
    act_cnt = 0; hs_low_cnt = 0; hs_first = -1; hs_last = -1; blank_rgb_cnt = 0;
    ls_cnt = 0; ls_idx = -1; fs_cnt = 0; xc_err = 0;
    for (int i = 0; i < 800; i++) begin
      tick();
      if (int'(word_def[22:13]) != (i + 2) % 800) xc_err++;
      if (word_def[0]) act_cnt++;
      if (!word_def[2]) begin
        hs_low_cnt++;
        if (hs_first < 0) hs_first = int'(word_def[22:13]);
        hs_last = int'(word_def[22:13]);
      end
      if (word_def[22:13] >= 10'd640 && word_def[25:23] != 3'b000) blank_rgb_cnt++;
      if (ls_def) begin ls_cnt++; ls_idx = i; end
      if (fs_def) fs_cnt++;
    end
    check("h_xc_sequence", 32'(xc_err), 32'(0));
    check("h_active_cnt", 32'(act_cnt), 32'(640));
    check("h_hs_low_cnt", 32'(hs_low_cnt), 32'(96));
    check("h_hs_first", 32'(hs_first), 32'(656));
    check("h_hs_last", 32'(hs_last), 32'(751));
    check("h_blank_rgb", 32'(blank_rgb_cnt), 32'(0));
    check("h_ls_cnt", 32'(ls_cnt), 32'(1));
    check("h_ls_period", 32'(ls_idx), 32'(798));
    check("h_fs_cnt", 32'(fs_cnt), 32'(0));
    check("h_end_word", 32'(word_def), 32'(mk(3'b101, 1, 1, 1'b1, 1'b1, 1'b1)));

    // Enable hold at XC=100.
    repeat (99) tick();
    check("en_pre_word", 32'(word_def), 32'(mk(3'b101, 100, 1, 1'b1, 1'b1, 1'b1)));
    en_def = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("en_hold_word", 32'(word_def), 32'(mk(3'b101, 100, 1, 1'b1, 1'b1, 1'b1)));
      check("en_hold_pulses", 32'({fs_def, ls_def}), 32'(0));
    end
    en_def = 1'b1;
    tick();
    check("en_resume_word", 32'(word_def), 32'(mk(3'b101, 101, 1, 1'b1, 1'b1, 1'b1)));

    // Asynchronous reset mid-line while HS is in its sync window.
    repeat (599) tick();
    check("pre_rst_word", 32'(word_def), 32'(mk(3'b000, 700, 1, 1'b0, 1'b1, 1'b0)));
    #2;
    rst_def = 1'b1;
    #1;
    check("async_rst_word", 32'(word_def), 32'(mk(3'b000, 0, 0, 1'b1, 1'b1, 1'b0)));
    check("async_rst_pulses", 32'({fs_def, ls_def}), 32'(0));
    #2;
    rst_def = 1'b0;
    tick();
    check("post_rst_word", 32'(word_def), 32'(mk(3'b101, 0, 0, 1'b1, 1'b1, 1'b1)));
    check("post_rst_fs", 32'(fs_def), 32'(1));

    // Small raster (8x6 = 48 cycles) and its inverted-polarity twin, one frame each.
    rst_sm = 1'b0; rst_pol = 1'b0; en_sm = 1'b1; en_pol = 1'b1;
    act_cnt = 0; vs_low_cnt = 0; vs_low_off = 0; hs_low_cnt = 0; fs_cnt = 0; fs_idx = -1;
    pol_hs_cnt = 0; pol_hs_off = 0; pol_vs_cnt = 0; last_sm = '0;
    for (int i = 0; i < 48; i++) begin
      tick();
      if (i == 0) begin
        check("pol_idle_origin", 32'(word_pol), 32'(mk(3'b101, 0, 0, 1'b0, 1'b0, 1'b1)));
      end
      if (word_sm[0]) act_cnt++;
      if (!word_sm[1]) begin
        vs_low_cnt++;
        if (word_sm[12:3] != 10'd4) vs_low_off++;
      end
      if (!word_sm[2]) hs_low_cnt++;
      if (fs_sm) begin fs_cnt++; fs_idx = i; end
      if (word_pol[2]) begin
        pol_hs_cnt++;
        if (word_pol[22:13] != 10'd5) pol_hs_off++;
      end
      if (word_pol[1]) pol_vs_cnt++;
      last_sm = word_sm;
    end
    check("v_active_cnt", 32'(act_cnt), 32'(12));
    check("v_vs_low_cnt", 32'(vs_low_cnt), 32'(8));
    check("v_vs_low_off_y4", 32'(vs_low_off), 32'(0));
    check("v_hs_low_cnt", 32'(hs_low_cnt), 32'(6));
    check("v_fs_cnt", 32'(fs_cnt), 32'(1));
    check("v_fs_idx", 32'(fs_idx), 32'(0));
    check("v_last_word", 32'(last_sm), 32'(mk(3'b000, 7, 5, 1'b1, 1'b1, 1'b0)));
    check("pol_hs_cnt", 32'(pol_hs_cnt), 32'(6));
    check("pol_hs_off_x5", 32'(pol_hs_off), 32'(0));
    check("pol_vs_cnt", 32'(pol_vs_cnt), 32'(8));
    tick();
    check("v_wrap_word", 32'(word_sm), 32'(mk(3'b101, 0, 0, 1'b1, 1'b1, 1'b1)));
    check("v_wrap_fs", 32'(fs_sm), 32'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pxs_stream_gen.md
Name: pxs_stream_gen

Overview:
- Source end of the 26-bit pixel stream consumed by the overlay stages (cursor, text, sprites): generates VGA raster timing and emits one stream word per px_clk.
- Stream word layout (fixed): [0] Active, [1] VS, [2] HS, [12:3] YC, [22:13] XC, [23] R, [24] G, [25] B.
- Sits at the head of the stream chain; RGB carries a background colour that downstream stages overwrite or invert.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, HS level during sync pulse (0 = active-low)
- VS_POL, 0, VS level during sync pulse (0 = active-low)

Ports:
- px_clk  input  1  pixel clock
- reset  input  1  asynchronous, active-high reset
- en  input  1  advance raster; low = hold
- bg_rgb  input  3  background colour {B,G,R}
- RGBStr_o  output  26  output RGB stream word (registered)
- frame_start  output  1  one-cycle pulse coincident with the stream word at XC=0, YC=0
- line_start  output  1  one-cycle pulse coincident with every stream word at XC=0

Behaviour:
- Derived constants:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP, which must be ≤ 1024.
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP, which must be ≤ 1024.
  - Elaboration fails otherwise.
- Internal 10-bit counters cx, cy:
  - Reset to 0.
  - When en=1 on each edge: cx increments; if cx = H_TOTAL-1, cx wraps to 0 and cy increments; if cy = V_TOTAL-1 at the same wrap, cy wraps to 0.
  - When en=0, cx and cy hold.
- Output register, loaded on every edge with en=1 from the current (cx,cy):
  - XC = cx, YC = cy.
  - Active = (cx < H_ACTIVE) && (cy < V_ACTIVE).
  - HS = HS_POL when H_ACTIVE+H_FP ≤ cx < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL.
  - VS = VS_POL when V_ACTIVE+V_FP ≤ cy < V_ACTIVE+V_FP+V_SYNC, else ~VS_POL. VS is evaluated per line, so it spans whole lines including their blanking.
  - RGB = bg_rgb sampled on the same edge if Active, else 3'b000.
  - frame_start = (cx==0 && cy==0); line_start = (cx==0).
- Latency: 1 cycle from counter value to stream word. All fields of one RGBStr_o word are mutually consistent (same pixel).
- en=0: RGBStr_o, frame_start and line_start hold their previous values. Pulses are not re-generated while held.
- Reset (asynchronous, any time including mid-frame):
  - RGBStr_o Active=0, XC=0, YC=0, RGB=0; HS=~HS_POL, VS=~VS_POL (inactive).
  - frame_start=0, line_start=0.
  - Counters cleared to 0.
  - First edge after release with en=1 emits pixel (0,0) with Active=1 and frame_start=1.
- bg_rgb changes take effect on the next emitted active word. There is no frame-level latching.
- No other state; no handshake (the stream is free-running, and downstream stages are pure pipelines).

Test Plan:
- Reset release, defaults, en=1, bg_rgb=3'b101 -> first word XC=0, YC=0, Active=1, RGB=101, HS=1, VS=1, frame_start=1, line_start=1. Next word XC=1, frame_start=0, line_start=0.
- Horizontal timing, defaults -> Active=1 for XC 0..639; HS=0 exactly for XC 656..751 (96 words); line_start period is 800 cycles; RGB=000 for XC ≥ 640.
- Vertical timing with small params (H 4/1/1/2, V 3/1/1/1) -> full frame 48 cycles; VS=0 for all 8 words of YC=4; Active words = 12; frame_start period is 48; YC wraps 5→0 at the XC 7→0 boundary.
- en toggling: drop en for 5 cycles mid-line at XC=100 -> RGBStr_o frozen at XC=100 for 5 cycles; resumes at XC=101; no extra line_start or frame_start pulse.
- Async reset asserted mid-frame (YC=200, XC=300) without a clock edge -> RGBStr_o immediately all-zero except HS=VS=1; after release, restarts at (0,0) with frame_start=1.
- Polarity params HS_POL=1, VS_POL=1 -> HS=1 only in the sync window; HS and VS idle low, including during reset.
